ca_code_nco: RTL and testbench

NCO-driven GPS C/A-code generator for one tracking channel. It generalises the fixed-rate C/A chip generator in three ways:
- a parametrised phase accumulator sets the chipping rate;
- it keeps code-phase and epoch bookkeeping, and provides early/prompt/late taps with one-chip spacing;
- a handshaked slew engine advances or retards code phase by an exact chip count.

It sits between the carrier/code NCO control loop and the correlators.

---
 rtl/ca_code_nco.sv | 133 +++++++++++++
 tb/tb_ca_code_nco.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ca_code_nco.sv
// ca_code_nco: NCO-paced GPS C/A code generator with early/prompt/late taps,
// code-phase/epoch bookkeeping and an exact chip-count slew engine.
module ca_code_nco #(
  parameter int NCO_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic             expanded,
  input  logic [3:0]       tap0,
  input  logic [3:0]       tap1,
  input  logic [10:1]      g2_init,
  input  logic [NCO_W-1:0] chip_rate,
  input  logic             slew_req,
  input  logic             slew_dir,
  input  logic [9:0]       slew_chips,
  output logic             slew_ack,
  output logic             busy,
  output logic             chip_e,
  output logic             chip_p,
  output logic             chip_l,
  output logic             chip_stb,
  output logic             epoch,
  output logic [9:0]       code_phase
);
  typedef enum logic {IDLE, SLEW} state_t;
  state_t           state_q, state_d;
  logic [10:1]      g1_q, g1_d, g2_q, g2_d;
  logic [NCO_W-1:0] acc_q, acc_d;
  logic [9:0]       rem_q, rem_d, phase_q, phase_d;
  logic             dir_q, dir_d, e_q, e_d, p_q, p_d, l_q, l_d;
  logic             stb_q, stb_d, epoch_q, epoch_d, ack_q, ack_d;
  logic [NCO_W:0]   sum;
  logic [15:0]      g2x;
  logic             carry, step, dec, gen_out;
  always_comb begin
    sum = {1'b0, acc_q} + {1'b0, chip_rate};
    carry = sum[NCO_W];
    // zero-padded so out-of-range tap values read 0 instead of X
    g2x = {5'b0, g2_q, 1'b0};
    gen_out = g1_q[10] ^ (expanded ? g2_q[10] : g2x[tap0] ^ g2x[tap1]);
    step = 1'b0;
    dec = 1'b0;
    state_d = state_q;
    g1_d = g1_q;
    g2_d = g2_q;
    acc_d = acc_q;
    rem_d = rem_q;
    phase_d = phase_q;
    dir_d = dir_q;
    e_d = e_q;
    p_d = p_q;
    l_d = l_q;
    stb_d = 1'b0;
    epoch_d = 1'b0;
    ack_d = 1'b0;
    if (start) begin
      state_d = IDLE;
      g1_d = '1;
      g2_d = expanded ? g2_init : '1;
      acc_d = '0;
      e_d = 1'b0;
      p_d = 1'b0;
      l_d = 1'b0;
      phase_d = 10'd1022;
    end else if (enable) begin
      acc_d = sum[NCO_W-1:0];
      step = (state_q == SLEW) ? dir_q : carry;
      // advance counts only the extra (non-carry) steps so the net lead is exact
      dec = (state_q == SLEW) && (dir_q ? !carry : carry);
      if (state_q == IDLE && slew_req) begin
        ack_d = 1'b1;
        dir_d = slew_dir;
        rem_d = slew_chips;
        state_d = (slew_chips != 10'd0) ? SLEW : IDLE;
      end
      if (dec) begin
        rem_d = rem_q - 10'd1;
        state_d = (rem_q == 10'd1) ? IDLE : SLEW;
      end
      if (step) begin
        g1_d = {g1_q[9:1], g1_q[10] ^ g1_q[3]};
        g2_d = {g2_q[9:1], g2_q[10] ^ g2_q[9] ^ g2_q[8] ^ g2_q[6] ^ g2_q[3] ^ g2_q[2]};
        e_d = gen_out;
        p_d = e_q;
        l_d = p_q;
        phase_d = (phase_q == 10'd1022) ? 10'd0 : phase_q + 10'd1;
      end
      stb_d = step;
      epoch_d = step && (phase_q == 10'd1022);
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      g1_q <= '1;
      g2_q <= '1;
      acc_q <= '0;
      rem_q <= '0;
      phase_q <= 10'd1022;
      dir_q <= 1'b0;
      e_q <= 1'b0;
      p_q <= 1'b0;
      l_q <= 1'b0;
      stb_q <= 1'b0;
      epoch_q <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      state_q <= state_d;
      g1_q <= g1_d;
      g2_q <= g2_d;
      acc_q <= acc_d;
      rem_q <= rem_d;
      phase_q <= phase_d;
      dir_q <= dir_d;
      e_q <= e_d;
      p_q <= p_d;
      l_q <= l_d;
      stb_q <= stb_d;
      epoch_q <= epoch_d;
      ack_q <= ack_d;
    end
  end
  assign slew_ack = ack_q;
  assign busy = (state_q == SLEW);
  assign chip_e = e_q;
  assign chip_p = p_q;
  assign chip_l = l_q;
  assign chip_stb = stb_q;
  assign epoch = epoch_q;
  assign code_phase = phase_q;
endmodule

// File: tb/tb_ca_code_nco.sv
// tb_ca_code_nco: scoreboard bench for the C/A code NCO (code sequences, slews,
// enable/start interaction and asynchronous reset).
module tb_ca_code_nco;
  localparam int W = 32;
  localparam logic [W-1:0] RATE4 = 32'h4000_0000;
  localparam logic [W-1:0] RATE8 = 32'h2000_0000;
  logic clk = 0, reset = 0, enable = 0, start = 0, expanded = 0;
  logic [3:0] tap0 = 4'd2, tap1 = 4'd6;
  logic [10:1] g2_init = '1;
  logic [W-1:0] chip_rate = '0;
  logic slew_req = 0, slew_dir = 0;
  logic [9:0] slew_chips = '0;
  logic slew_ack, busy, chip_e, chip_p, chip_l, chip_stb, epoch;
  logic [9:0] code_phase;
  int errors = 0, checks = 0;
  logic [W-1:0] ref_acc = '0;
  int ref_ph = 1022;
  logic ref_carry = 0;
  typedef struct packed {logic e; logic p; logic l; logic ep; logic [9:0] ph;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  ca_code_nco #(.NCO_W(W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .expanded(expanded),
    .tap0(tap0), .tap1(tap1), .g2_init(g2_init), .chip_rate(chip_rate),
    .slew_req(slew_req), .slew_dir(slew_dir), .slew_chips(slew_chips),
    .slew_ack(slew_ack), .busy(busy), .chip_e(chip_e), .chip_p(chip_p), .chip_l(chip_l),
    .chip_stb(chip_stb), .epoch(epoch), .code_phase(code_phase)
  );

  // Unslewed reference: accumulator and code phase advanced from the inputs seen at each edge.
  task automatic cyc();
    logic [W:0] s;
    ref_carry = 0;
    if (!reset || start) begin
      ref_acc = '0;
      ref_ph = 1022;
    end else if (enable) begin
      s = {1'b0, ref_acc} + {1'b0, chip_rate};
      ref_acc = s[W-1:0];
      ref_carry = s[W];
      if (ref_carry) ref_ph = (ref_ph + 1) % 1023;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1;
    cyc();
    start = 0;
  endtask

  task automatic test_reset();
    reset = 0; enable = 1; chip_rate = RATE4;
    repeat (2) cyc();
    checks++;
    if ({chip_e, chip_p, chip_l, chip_stb, epoch, slew_ack, busy} !== 7'b0) begin
      errors++; $display("FAIL reset_outs: got %b want 0000000", {chip_e, chip_p, chip_l, chip_stb, epoch, slew_ack, busy});
    end
    checks++;
    if (code_phase !== 10'd1022) begin errors++; $display("FAIL reset_phase: got %0d want 1022", code_phase); end
    #2 reset = 1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      checks++;
      if (chip_stb !== (i == 4)) begin errors++; $display("FAIL reset_first_step edge %0d: got %b want %b", i, chip_stb, i == 4); end
    end
    checks++;
    if (epoch !== 1'b1 || code_phase !== 10'd0) begin errors++; $display("FAIL reset_epoch: got ep=%b ph=%0d want ep=1 ph=0", epoch, code_phase); end
  endtask

  task automatic run_code(input logic ex, input int t0, input int t1, input logic [10:1] init,
                          input int nsteps, input logic [9:0] first10, input string nm);
    logic [10:1] mg1, mg2;
    logic c, pe, pp;
    logic [9:0] f10;
    int gap, guard, k;
    exp_t x;
    expanded = ex; tap0 = 4'(t0); tap1 = 4'(t1); g2_init = init; chip_rate = RATE4; enable = 1;
    mg1 = '1; mg2 = ex ? init : '1; pe = 0; pp = 0; f10 = '0; gap = 0; guard = 0; k = 0;
    sb.delete();
    for (int n = 0; n < nsteps; n++) begin
      c = mg1[10] ^ (ex ? mg2[10] : mg2[t0] ^ mg2[t1]);
      x.e = c; x.p = pe; x.l = pp; x.ep = (n % 1023 == 0); x.ph = 10'(n % 1023);
      sb.push_back(x);
      pp = pe; pe = c;
      mg1 = {mg1[9:1], ^(mg1 & 10'b1000000100)};
      mg2 = {mg2[9:1], ^(mg2 & 10'b1110100110)};
    end
    pulse_start();
    checks++;
    if ({chip_e, chip_p, chip_l, code_phase} !== {3'b000, 10'd1022}) begin
      errors++; $display("FAIL %s_start: got %b/%0d want 000/1022", nm, {chip_e, chip_p, chip_l}, code_phase);
    end
    while (sb.size() > 0 && guard < nsteps * 4 + 20) begin
      cyc(); guard++; gap++;
      if (chip_stb) begin
        x = sb.pop_front();
        checks++;
        if ({chip_e, chip_p, chip_l, epoch, code_phase} !== x) begin
          errors++; $display("FAIL %s_step %0d: got e/p/l/ep=%b ph=%0d want %b ph=%0d", nm, k,
                             {chip_e, chip_p, chip_l, epoch}, code_phase, {x.e, x.p, x.l, x.ep}, x.ph);
        end
        checks++;
        if (gap !== 4) begin errors++; $display("FAIL %s_stb_gap %0d: got %0d want 4", nm, k, gap); end
        if (k < 10) f10 = {f10[8:0], chip_e};
        gap = 0; k++;
      end else begin
        checks++;
        if (epoch !== 1'b0) begin errors++; $display("FAIL %s_stray_epoch: got 1 want 0", nm); end
      end
    end
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL %s_timeout: got %0d pending want 0", nm, sb.size()); end
    checks++;
    if (f10 !== first10) begin errors++; $display("FAIL %s_first10: got %o want %o", nm, f10, first10); end
  endtask

  task automatic test_prn1();
    run_code(1'b0, 2, 6, 10'h3ff, 1030, 10'o1440, "prn1");
  endtask

  task automatic test_prn38();
    run_code(1'b1, 1, 1, 10'o0017, 2046, 10'o1760, "prn38");
  endtask

  task automatic test_retard();
    int n, cy, acks, stbs;
    expanded = 0; tap0 = 4'd2; tap1 = 4'd6; chip_rate = RATE4; enable = 1;
    pulse_start();
    repeat (21) cyc();
    slew_dir = 0; slew_chips = 10'd5; slew_req = 1;
    cyc();
    slew_req = 0;
    checks++;
    if ({slew_ack, busy} !== 2'b11) begin errors++; $display("FAIL retard_ack: got ack/busy=%b want 11", {slew_ack, busy}); end
    n = 0; cy = 0; acks = 0; stbs = 0;
    while (busy && cy < 200) begin
      cyc(); cy++;
      if (ref_carry) n++;
      if (slew_ack) acks++;
      if (chip_stb) stbs++;
    end
    checks++;
    if (busy !== 1'b0 || n !== 5) begin errors++; $display("FAIL retard_len: got busy=%b carries=%0d want 0/5", busy, n); end
    checks++;
    if (acks !== 0 || stbs !== 0) begin errors++; $display("FAIL retard_pulses: got acks=%0d stbs=%0d want 0/0", acks, stbs); end
    repeat (13) cyc();
    checks++;
    if (code_phase !== 10'((ref_ph + 1018) % 1023)) begin
      errors++; $display("FAIL retard_phase: got %0d want %0d", code_phase, (ref_ph + 1018) % 1023);
    end
  endtask

  task automatic test_advance();
    int n, cy, miss, rises;
    chip_rate = RATE8; enable = 1;
    pulse_start();
    repeat (30) cyc();
    slew_dir = 1; slew_chips = 10'd1000; slew_req = 1;
    cyc();
    slew_req = 0;
    checks++;
    if ({slew_ack, busy} !== 2'b11) begin errors++; $display("FAIL advance_ack: got ack/busy=%b want 11", {slew_ack, busy}); end
    n = 0; cy = 0; miss = 0;
    while (busy && cy < 3000) begin
      cyc(); cy++;
      if (ref_carry) n++;
      if (!chip_stb) miss++;
    end
    checks++;
    if (busy !== 1'b0 || cy !== 1000 + n) begin errors++; $display("FAIL advance_len: got busy=%b cycles=%0d want 0/%0d", busy, cy, 1000 + n); end
    checks++;
    if (miss !== 0) begin errors++; $display("FAIL advance_stb: got %0d missing strobes want 0", miss); end
    checks++;
    if (code_phase !== 10'((ref_ph + 1000) % 1023)) begin
      errors++; $display("FAIL advance_phase: got %0d want %0d", code_phase, (ref_ph + 1000) % 1023);
    end
    slew_chips = 10'd0; slew_req = 1;
    cyc();
    slew_req = 0;
    checks++;
    if ({slew_ack, busy} !== 2'b10) begin errors++; $display("FAIL zero_slew_ack: got ack/busy=%b want 10", {slew_ack, busy}); end
    rises = 0;
    repeat (9) begin cyc(); if (busy) rises++; end
    checks++;
    if (rises !== 0 || code_phase !== 10'((ref_ph + 1000) % 1023)) begin
      errors++; $display("FAIL zero_slew_hold: got busy_cycles=%0d ph=%0d want 0/%0d", rises, code_phase, (ref_ph + 1000) % 1023);
    end
  endtask

  task automatic test_enable_start();
    logic [9:0] ph;
    logic [2:0] taps;
    int bad, cy;
    chip_rate = RATE4; enable = 1;
    pulse_start();
    repeat (10) cyc();
    slew_dir = 1; slew_chips = 10'd300; slew_req = 1;
    cyc();
    slew_req = 0;
    repeat (50) cyc();
    ph = code_phase; taps = {chip_e, chip_p, chip_l};
    enable = 0; bad = 0;
    for (int i = 0; i < 17; i++) begin
      cyc();
      if ({chip_stb, epoch, slew_ack} !== 3'b0 || code_phase !== ph || {chip_e, chip_p, chip_l} !== taps || busy !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL enable_hold: got %0d disturbed cycles want 0", bad); end
    enable = 1; cy = 0;
    while (busy && cy < 1000) begin cyc(); cy++; end
    checks++;
    if (busy !== 1'b0 || code_phase !== 10'((ref_ph + 300) % 1023)) begin
      errors++; $display("FAIL enable_slew_phase: got busy=%b ph=%0d want 0/%0d", busy, code_phase, (ref_ph + 300) % 1023);
    end
    slew_dir = 0; slew_chips = 10'd100; slew_req = 1;
    cyc();
    slew_req = 0;
    repeat (3) cyc();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL abort_pre_busy: got %b want 1", busy); end
    pulse_start();
    checks++;
    if (busy !== 1'b0 || code_phase !== 10'd1022 || chip_stb !== 1'b0) begin
      errors++; $display("FAIL abort_start: got busy=%b ph=%0d stb=%b want 0/1022/0", busy, code_phase, chip_stb);
    end
    start = 1; slew_req = 1; slew_chips = 10'd5;
    cyc();
    start = 0; slew_req = 0;
    checks++;
    if ({slew_ack, busy} !== 2'b00) begin errors++; $display("FAIL start_vs_req: got ack/busy=%b want 00", {slew_ack, busy}); end
    cyc();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL start_vs_req_busy: got %b want 0", busy); end
  endtask

  task automatic test_async_reset();
    chip_rate = RATE4; enable = 1;
    pulse_start();
    repeat (9) cyc();
    #2 reset = 0;
    #1;
    checks++;
    if ({chip_e, chip_p, chip_l, chip_stb, epoch, slew_ack, busy} !== 7'b0 || code_phase !== 10'd1022) begin
      errors++; $display("FAIL async_reset: got %b ph=%0d want 0000000 ph=1022",
                         {chip_e, chip_p, chip_l, chip_stb, epoch, slew_ack, busy}, code_phase);
    end
    repeat (2) cyc();
    #2 reset = 1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      checks++;
      if (chip_stb !== (i == 4)) begin errors++; $display("FAIL async_release edge %0d: got %b want %b", i, chip_stb, i == 4); end
    end
  endtask

  initial begin
    test_reset();
    test_prn1();
    test_prn38();
    test_retard();
    test_advance();
    test_enable_start();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
